// File: rtl/addsub_rr_scheduler.sv
// ---------------------------------------------------------------------------
// addsub_rr_scheduler
//
// Lets two requesters share one combinational WIDTH-bit adder/subtractor.
// One operation is in flight at a time. When the block is idle it picks a
// requester round-robin and latches that requester's operands onto the
// datapath. It holds them there for SETTLE cycles, then captures the
// datapath's {cout,s}. The captured result is returned on the winner's
// response channel and held until the requester takes it.
//
// Parameters
//   WIDTH   operand / result width (datapath returns WIDTH+1 bits)
//   SETTLE  cycles the operands are held on dp_* before capture (>= 1)
//
// Ports
//   clk, rst_n                rising-edge clock, async active-low reset
//   req{0,1}_valid / _ready   operation request handshake
//   req{0,1}_a / _b           operands
//   req{0,1}_op               0 = add, 1 = subtract (larger minus smaller)
//   resp{0,1}_valid / _ready  result handshake, one channel per requester
//   resp_s, resp_cout         captured result, shared by both channels
//   dp_a, dp_b, dp_ctrl       operands / op select to the shared datapath
//   dp_s, dp_cout             result returned by the shared datapath
// ---------------------------------------------------------------------------
module addsub_rr_scheduler #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,

    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_s,
    output logic             resp_cout,

    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_ctrl,
    input  logic [WIDTH-1:0] dp_s,
    input  logic             dp_cout
);

    // The settle counter needs at least one bit even when SETTLE == 1.
    localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant_id;
    logic [CNT_W-1:0] cnt;

    logic             any_req;
    logic             grant_sel;
    logic             accept;
    logic             capture;
    logic             resp_done;

    // Round-robin pick. When both requesters are asking, the one that did not
    // win last time gets the grant. A lone requester always wins.
    always_comb begin
        any_req   = req0_valid | req1_valid;
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = req1_valid;
        end
    end

    // Handshake and control decodes. Ready is offered only in IDLE, and only
    // to the requester that would win the grant this cycle.
    always_comb begin
        req0_ready  = (state == IDLE) && any_req && !grant_sel;
        req1_ready  = (state == IDLE) && any_req &&  grant_sel;
        accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        capture     = (state == ISSUE) && (cnt == '0);
        resp0_valid = (state == RESP) && !grant_id;
        resp1_valid = (state == RESP) &&  grant_id;
        resp_done   = (state == RESP) && (grant_id ? resp1_ready : resp0_ready);
    end

    // Next-state logic: IDLE -> ISSUE on accept, ISSUE -> RESP on the final
    // settle cycle, and RESP -> IDLE once the winner takes the result.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (capture) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, grant bookkeeping and settle counter.
    // last_grant resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            cnt        <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                grant_id   <= grant_sel;
                last_grant <= grant_sel;
                cnt        <= CNT_LOAD;
            end else if ((state == ISSUE) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Datapath operand registers. They load only on an accepted request, so
    // the shared adder never sees unlatched requester inputs. They also keep
    // their last value between operations instead of toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a    <= '0;
            dp_b    <= '0;
            dp_ctrl <= 1'b0;
        end else if (accept) begin
            dp_a    <= grant_sel ? req1_a  : req0_a;
            dp_b    <= grant_sel ? req1_b  : req0_b;
            dp_ctrl <= grant_sel ? req1_op : req0_op;
        end
    end

    // Result capture on the last ISSUE cycle. The result stays stable through
    // RESP and until the next operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_s    <= '0;
            resp_cout <= 1'b0;
        end else if (capture) begin
            resp_s    <= dp_s;
            resp_cout <= dp_cout;
        end
    end

endmodule
